chirp_sync_sched: RTL and testbench
===================================

Name: chirp_sync_sched

Overview:
Sequences the chirp-sync counter from the external GPIO sync square wave. Once armed, it synchronises SIG and waits for a low-then-rising edge. It then issues load/enable/trigger controls to the downstream chirp counter and counts completed chirps until the programmed burst finishes, a timeout fires, or software disarms. It sits between the GPIO pin and the chirp counter and replaces free-running edge logic with a software-controlled burst scheduler.

Parameters:
CNT_W, 16, width of CHIRP_LEN bus passed to the counter
SYNC_STAGES, 2, SIG synchroniser depth (>=2)
TMO_W, 24, width of edge-wait timeout counter
FILT_LEN, 4, glitch-filter stability length in cycles (used only with the optional feature)

Ports:
CLK  in  1  system clock
RSET  in  1  synchronous reset, active-high
SIG  in  1  asynchronous external sync square wave
ARM  in  1  one-cycle pulse: start burst (ignored while BUSY)
DISARM  in  1  level/pulse: abort to IDLE
CHIRP_LEN  in  CNT_W  counter load value, latched on accepted ARM
NUM_CHIRPS  in  8  chirps per burst, latched on ARM; 0 = continuous
TIMEOUT  in  TMO_W  max cycles in WAIT_EDGE; 0 = no timeout
CNT_TC  in  1  terminal-count from chirp counter
CNT_LOAD  out  1  load pulse to counter
CNT_LVAL  out  CNT_W  latched CHIRP_LEN
CNT_EN  out  1  counter enable
CNT_UD  out  1  count direction, constant 1 (up)
TRIG  out  1  one-cycle chirp-start trigger
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse at burst completion
CHIRP_IDX  out  8  completed chirps in current burst
TMO_ERR  out  1  sticky: edge-wait timeout
OVR_ERR  out  1  sticky: SIG rising edge seen during RUN

Behaviour:
- Reset (RSET=1 at CLK edge): state IDLE. All outputs 0 except CNT_UD=1. Synchroniser flops, CHIRP_IDX, latched values and both sticky flags are cleared.
- Synchroniser: sig_s is the output of SYNC_STAGES flops. sig_d is sig_s delayed one cycle. A rise is sig_s=1 and sig_d=0.
- Outputs are registered/Moore, decoded from state:
  - CNT_LOAD=1 and TRIG=1 only in LOAD.
  - CNT_EN=1 only in RUN.
  - DONE=1 only in FIN.
- State transitions:
  - IDLE: ARM -> WAIT_LOW. Latch CHIRP_LEN and NUM_CHIRPS, clear CHIRP_IDX, TMO_ERR and OVR_ERR.
  - WAIT_LOW: sig_s=0 -> WAIT_EDGE. A SIG already high at arm never triggers.
  - WAIT_EDGE: rise -> LOAD. The timeout counter increments each cycle in this state and clears on entry. When TIMEOUT!=0 and the count reaches TIMEOUT-1 with no rise -> IDLE, TMO_ERR set. A rise in that same cycle wins.
  - LOAD: single cycle -> RUN.
  - RUN: CNT_TC=1 -> CHIRP_IDX+1. Then -> FIN if the new index equals NUM_CHIRPS (NUM_CHIRPS!=0), else -> WAIT_LOW. A rise while in RUN sets OVR_ERR and does not restart the counter.
  - FIN: single cycle -> IDLE.
- CHIRP_IDX wraps 255->0 in continuous mode.
- Latency: let edge k be the first CLK edge sampling SIG=1 after SIG has been low in WAIT_EDGE. CNT_LOAD/TRIG are high in the cycle after edge k+SYNC_STAGES. CNT_EN is high from the next cycle.
- DISARM=1 in any state -> IDLE on the next edge, with CNT_EN/CNT_LOAD/TRIG low from then on. CHIRP_IDX and sticky flags are held. DISARM has priority over ARM in the same cycle.
- ARM while BUSY: ignored, latched values are unchanged.
- RSET mid-burst: immediate return to reset values on that edge.
- CNT_TC outside RUN: ignored.

Optional Feature:
CHIRP_SYNC_GLITCH_FILT_EN
- Defined: sig_s only changes after the synchroniser output holds a new value for FILT_LEN consecutive cycles. Pulses shorter than FILT_LEN are rejected. Latency grows by FILT_LEN cycles.
- Undefined: no filter, and latency is exactly as stated under Behaviour.

Test Plan:
- RSET=1 for 2 cycles, then low: all outputs 0, CNT_UD=1, BUSY=0, CHIRP_IDX=0.
- CHIRP_LEN=0x0100, NUM_CHIRPS=3, ARM, SIG square wave with CNT_TC pulsed 10 cycles after each CNT_EN rise -> three LOAD/TRIG pulses, CNT_LVAL=0x0100, CHIRP_IDX 1,2,3, one DONE pulse, BUSY falls the cycle after DONE.
- SIG held high before ARM, then falls, then rises -> no TRIG until after the fall; CNT_LOAD occurs the cycle after edge k+2 (SYNC_STAGES=2).
- TIMEOUT=100, SIG held low after ARM -> TMO_ERR=1 and state IDLE after 100 WAIT_EDGE cycles, no TRIG. Next ARM clears TMO_ERR.
- SIG rising edge during RUN -> OVR_ERR=1, CNT_EN stays high, no extra CNT_LOAD. DISARM mid-RUN -> CNT_EN=0 next cycle, CHIRP_IDX held.
- With CHIRP_SYNC_GLITCH_FILT_EN defined and FILT_LEN=4, a 2-cycle SIG pulse -> no TRIG, while a 6-cycle pulse -> TRIG. Without the macro, the 2-cycle pulse -> TRIG.

Source files
------------

// File: rtl/chirp_sync_if.sv
// Control/status bundle between the chirp-sync burst scheduler and its neighbours
// (GPIO sync input, software controls, downstream chirp counter).
interface chirp_sync_if #(
   parameter int CNT_W = 16,
   parameter int TMO_W = 24
);
   logic             SIG;
   logic             ARM;
   logic             DISARM;
   logic [CNT_W-1:0] CHIRP_LEN;
   logic [7:0]       NUM_CHIRPS;
   logic [TMO_W-1:0] TIMEOUT;
   logic             CNT_TC;
   logic             CNT_LOAD;
   logic [CNT_W-1:0] CNT_LVAL;
   logic             CNT_EN;
   logic             CNT_UD;
   logic             TRIG;
   logic             BUSY;
   logic             DONE;
   logic [7:0]       CHIRP_IDX;
   logic             TMO_ERR;
   logic             OVR_ERR;

   modport master (
      output SIG, ARM, DISARM, CHIRP_LEN, NUM_CHIRPS, TIMEOUT, CNT_TC,
      input  CNT_LOAD, CNT_LVAL, CNT_EN, CNT_UD, TRIG, BUSY, DONE,
             CHIRP_IDX, TMO_ERR, OVR_ERR
   );

   modport slave (
      input  SIG, ARM, DISARM, CHIRP_LEN, NUM_CHIRPS, TIMEOUT, CNT_TC,
      output CNT_LOAD, CNT_LVAL, CNT_EN, CNT_UD, TRIG, BUSY, DONE,
             CHIRP_IDX, TMO_ERR, OVR_ERR
   );
endinterface

// File: rtl/chirp_sync_sched.sv
// Software-armed burst scheduler: waits for a low-then-rising GPIO sync edge and drives the chirp counter.
// Optional glitch filter on the synchronised SIG: define CHIRP_SYNC_GLITCH_FILT_EN.
module chirp_sync_sched #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TMO_W       = 24,
   parameter int FILT_LEN    = 4
) (
   input logic         CLK,
   input logic         RSET,
   chirp_sync_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_LOW, S_WAIT_EDGE, S_LOAD, S_RUN, S_FIN
   } state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] sig_sync;
   logic                   sync_raw, sig_s, sig_d, rise;
   logic [TMO_W-1:0]       tmo_cnt;
   logic [CNT_W-1:0]       lval;
   logic [7:0]             num_q, idx, idx_inc;
   logic                   tmo_err, ovr_err;
   logic                   tmo_hit, arm_acc, tc_acc, ovr_hit;

   // Stage p0: metastability synchroniser and edge detector
   always_ff @(posedge CLK) begin
      if (RSET) begin
         sig_sync <= '0;
         sig_d    <= 1'b0;
      end else begin
         sig_sync <= {sig_sync[SYNC_STAGES-2:0], bus.SIG};
         sig_d    <= sig_s;
      end
   end

   assign sync_raw = sig_sync[SYNC_STAGES-1];

`ifdef CHIRP_SYNC_GLITCH_FILT_EN
   localparam int FC_W = $clog2(FILT_LEN + 1);
   logic [FC_W-1:0] filt_cnt;
   logic            sig_f;

   // The filtered level only follows a new value that has held for FILT_LEN samples.
   always_ff @(posedge CLK) begin
      if (RSET) begin
         sig_f    <= 1'b0;
         filt_cnt <= '0;
      end else if (sync_raw == sig_f) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
         sig_f    <= sync_raw;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FC_W'(1);
      end
   end

   assign sig_s = sig_f;
`else
   logic filt_unused;
   assign filt_unused = (FILT_LEN != 0);
   assign sig_s       = sync_raw;
`endif

   assign rise    = sig_s & ~sig_d;
   assign idx_inc = idx + 8'd1;
   assign arm_acc = (state == S_IDLE) && bus.ARM && !bus.DISARM;
   assign tc_acc  = (state == S_RUN) && bus.CNT_TC && !bus.DISARM;
   assign ovr_hit = (state == S_RUN) && rise && !bus.DISARM;

   always_comb begin
      state_n = state;
      tmo_hit = 1'b0;
      case (state)
         S_IDLE:      if (bus.ARM) state_n = S_WAIT_LOW;
         S_WAIT_LOW:  if (!sig_s) state_n = S_WAIT_EDGE;
         S_WAIT_EDGE: begin
            // A rise in the final timeout cycle still wins.
            if (rise) begin
               state_n = S_LOAD;
            end else if ((bus.TIMEOUT != '0) && (tmo_cnt == bus.TIMEOUT - TMO_W'(1))) begin
               state_n = S_IDLE;
               tmo_hit = 1'b1;
            end
         end
         S_LOAD:      state_n = S_RUN;
         S_RUN: begin
            if (bus.CNT_TC) begin
               if ((num_q != 8'd0) && (idx_inc == num_q)) state_n = S_FIN;
               else                                        state_n = S_WAIT_LOW;
            end
         end
         S_FIN:       state_n = S_IDLE;
         default:     state_n = S_IDLE;
      endcase
      if (bus.DISARM) begin
         state_n = S_IDLE;
         tmo_hit = 1'b0;
      end
   end

   // Stage p1: state, latched burst parameters, chirp index and sticky flags
   always_ff @(posedge CLK) begin
      if (RSET) begin
         state   <= S_IDLE;
         tmo_cnt <= '0;
         lval    <= '0;
         num_q   <= 8'd0;
         idx     <= 8'd0;
         tmo_err <= 1'b0;
         ovr_err <= 1'b0;
      end else begin
         state   <= state_n;
         tmo_cnt <= (state == S_WAIT_EDGE) ? tmo_cnt + TMO_W'(1) : '0;
         if (arm_acc) begin
            lval    <= bus.CHIRP_LEN;
            num_q   <= bus.NUM_CHIRPS;
            idx     <= 8'd0;
            tmo_err <= 1'b0;
            ovr_err <= 1'b0;
         end
         if (tc_acc)  idx     <= idx_inc;
         if (tmo_hit) tmo_err <= 1'b1;
         if (ovr_hit) ovr_err <= 1'b1;
      end
   end

   assign bus.CNT_LOAD  = (state == S_LOAD);
   assign bus.TRIG      = (state == S_LOAD);
   assign bus.CNT_EN    = (state == S_RUN);
   assign bus.DONE      = (state == S_FIN);
   assign bus.BUSY      = (state != S_IDLE);
   assign bus.CNT_UD    = 1'b1;
   assign bus.CNT_LVAL  = lval;
   assign bus.CHIRP_IDX = idx;
   assign bus.TMO_ERR   = tmo_err;
   assign bus.OVR_ERR   = ovr_err;
endmodule

// File: tb/tb_chirp_sync_sched.sv
// Scoreboard bench for chirp_sync_sched: directed stimulus pushes expected LOAD/DONE events, a monitor pops them.
module tb_chirp_sync_sched;
   localparam int FILT_LEN = 4;
`ifdef CHIRP_SYNC_GLITCH_FILT_EN
   localparam int LAT = 3 + FILT_LEN;
`else
   localparam int LAT = 3;
`endif

   typedef struct {
      int          kind;   // 0 = LOAD/TRIG, 1 = DONE
      int          cyc;    // required cycle, -1 = any
      logic [15:0] lval;
      logic [7:0]  idx;
   } exp_t;

   logic clk, rset;
   int   cyc;
   int   checks, errors;
   int   tc_auto, tc_delay;
   exp_t exp_q[$];

   chirp_sync_if #(.CNT_W(16), .TMO_W(24)) bus ();

   chirp_sync_sched #(.CNT_W(16), .SYNC_STAGES(2), .TMO_W(24), .FILT_LEN(FILT_LEN)) dut (
      .CLK(clk), .RSET(rset), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_load(input logic [15:0] lv, input logic [7:0] ix, input int at);
      exp_t e;
      e.kind = 0; e.cyc = at; e.lval = lv; e.idx = ix;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input logic [7:0] ix);
      exp_t e;
      e.kind = 1; e.cyc = -1; e.lval = 16'h0; e.idx = ix;
      exp_q.push_back(e);
   endtask

   task automatic arm_pulse(input logic [15:0] len, input logic [7:0] num);
      bus.CHIRP_LEN  = len;
      bus.NUM_CHIRPS = num;
      bus.ARM        = 1'b1;
      step(1);
      bus.ARM        = 1'b0;
   endtask

   // Monitor: compare every LOAD/DONE the DUT presents against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rset && (bus.CNT_LOAD === 1'b1 || bus.DONE === 1'b1)) begin
            if (exp_q.size() == 0) begin
               chk(bus.DONE ? "unexpected_done" : "unexpected_load", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", bus.DONE ? 32'd1 : 32'd0, e.kind);
               if (e.kind == 0) begin
                  chk("load_trig", {31'd0, bus.TRIG}, 32'd1);
                  chk("load_lval", {16'd0, bus.CNT_LVAL}, {16'd0, e.lval});
                  chk("load_idx", {24'd0, bus.CHIRP_IDX}, {24'd0, e.idx});
                  if (e.cyc >= 0) chk("load_latency", cyc, e.cyc);
               end else begin
                  chk("done_idx", {24'd0, bus.CHIRP_IDX}, {24'd0, e.idx});
                  @(negedge clk);
                  chk("busy_after_done", {31'd0, bus.BUSY}, 32'd0);
               end
            end
         end
      end
   end

   // Chirp counter model: terminal count tc_delay cycles after each CNT_EN rise.
   initial begin
      logic en_prev;
      en_prev    = 1'b0;
      bus.CNT_TC = 1'b0;
      forever begin
         @(negedge clk);
         if (tc_auto != 0 && bus.CNT_EN === 1'b1 && !en_prev) begin
            repeat (tc_delay - 1) @(posedge clk);
            #1 bus.CNT_TC = 1'b1;
            @(posedge clk);
            #1 bus.CNT_TC = 1'b0;
         end
         en_prev = (bus.CNT_EN === 1'b1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      checks = 0; errors = 0;
      tc_auto = 0; tc_delay = 10;
      rset = 1'b1;
      bus.SIG = 1'b0; bus.ARM = 1'b0; bus.DISARM = 1'b0;
      bus.CHIRP_LEN = 16'h0; bus.NUM_CHIRPS = 8'd0; bus.TIMEOUT = 24'd0;
      step(2);
      rset = 1'b0;
      @(negedge clk);
      chk("rst_load", {31'd0, bus.CNT_LOAD}, 32'd0);
      chk("rst_trig", {31'd0, bus.TRIG}, 32'd0);
      chk("rst_en", {31'd0, bus.CNT_EN}, 32'd0);
      chk("rst_ud", {31'd0, bus.CNT_UD}, 32'd1);
      chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("rst_done", {31'd0, bus.DONE}, 32'd0);
      chk("rst_idx", {24'd0, bus.CHIRP_IDX}, 32'd0);
      chk("rst_lval", {16'd0, bus.CNT_LVAL}, 32'd0);
      chk("rst_errs", {30'd0, bus.TMO_ERR, bus.OVR_ERR}, 32'd0);

      // Three-chirp burst on a 40-cycle square wave
      tc_auto = 1;
      step(1);
      arm_pulse(16'h0100, 8'd3);
      for (int i = 0; i < 3; i++) push_load(16'h0100, 8'(i), -1);
      push_done(8'd3);
      step(3);
      for (int i = 0; i < 3; i++) begin
         bus.SIG = 1'b1; step(20);
         bus.SIG = 1'b0; step(20);
      end
      chk("burst_idx", {24'd0, bus.CHIRP_IDX}, 32'd3);
      chk("burst_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("burst_ovr", {31'd0, bus.OVR_ERR}, 32'd0);
      chk("burst_q", exp_q.size(), 32'd0);

      // SIG already high at ARM must fall before a rise can trigger
      bus.SIG = 1'b1; step(5);
      arm_pulse(16'h1234, 8'd1);
      step(10);
      chk("high_arm_busy", {31'd0, bus.BUSY}, 32'd1);
      bus.SIG = 1'b0; step(12);
      bus.SIG = 1'b1;
      c0 = cyc;
      push_load(16'h1234, 8'd0, c0 + LAT);
      push_done(8'd1);
      step(35);
      bus.SIG = 1'b0; step(5);
      chk("latency_q", exp_q.size(), 32'd0);

      // Edge-wait timeout of 100 cycles, then a re-ARM clears it
      bus.TIMEOUT = 24'd100;
      arm_pulse(16'h0077, 8'd1);
      step(100);
      chk("tmo_busy_before", {31'd0, bus.BUSY}, 32'd1);
      chk("tmo_err_before", {31'd0, bus.TMO_ERR}, 32'd0);
      step(1);
      chk("tmo_busy_after", {31'd0, bus.BUSY}, 32'd0);
      chk("tmo_err_after", {31'd0, bus.TMO_ERR}, 32'd1);
      bus.TIMEOUT = 24'd0;
      arm_pulse(16'h00AB, 8'd0);
      chk("rearm_tmo_clr", {31'd0, bus.TMO_ERR}, 32'd0);
      chk("rearm_busy", {31'd0, bus.BUSY}, 32'd1);

      // Overrun during RUN, ARM while busy, DISARM mid-RUN, TC while idle
      tc_delay = 30;
      push_load(16'h00AB, 8'd0, -1);
      step(3);
      bus.SIG = 1'b1; step(12);
      bus.SIG = 1'b0; step(8);
      bus.SIG = 1'b1; step(10);
      chk("ovr_set", {31'd0, bus.OVR_ERR}, 32'd1);
      chk("ovr_en_held", {31'd0, bus.CNT_EN}, 32'd1);
      arm_pulse(16'h5555, 8'd9);
      chk("busy_arm_lval", {16'd0, bus.CNT_LVAL}, 32'h00AB);
      step(10);
      chk("cont_idx1", {24'd0, bus.CHIRP_IDX}, 32'd1);
      chk("cont_en_off", {31'd0, bus.CNT_EN}, 32'd0);
      bus.SIG = 1'b0; step(10);
      push_load(16'h00AB, 8'd1, -1);
      bus.SIG = 1'b1; step(12);
      chk("run2_en", {31'd0, bus.CNT_EN}, 32'd1);
      bus.DISARM = 1'b1; step(1); bus.DISARM = 1'b0;
      chk("disarm_en", {31'd0, bus.CNT_EN}, 32'd0);
      chk("disarm_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("disarm_idx", {24'd0, bus.CHIRP_IDX}, 32'd1);
      chk("disarm_ovr_held", {31'd0, bus.OVR_ERR}, 32'd1);
      step(30);
      chk("idle_tc_idx", {24'd0, bus.CHIRP_IDX}, 32'd1);
      bus.SIG = 1'b0;
      tc_delay = 10;
      step(5);

      // DISARM beats ARM in the same cycle
      bus.DISARM = 1'b1;
      arm_pulse(16'h0999, 8'd1);
      bus.DISARM = 1'b0;
      chk("disarm_prio_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("disarm_prio_lval", {16'd0, bus.CNT_LVAL}, 32'h00AB);

      // Short SIG pulses
      arm_pulse(16'h0042, 8'd1);
      step(3);
`ifdef CHIRP_SYNC_GLITCH_FILT_EN
      bus.SIG = 1'b1; step(2); bus.SIG = 1'b0; step(15);
      chk("glitch_rejected_busy", {31'd0, bus.BUSY}, 32'd1);
      push_load(16'h0042, 8'd0, -1);
      push_done(8'd1);
      bus.SIG = 1'b1; step(6); bus.SIG = 1'b0; step(40);
`else
      push_load(16'h0042, 8'd0, -1);
      push_done(8'd1);
      bus.SIG = 1'b1; step(2); bus.SIG = 1'b0; step(30);
`endif
      chk("pulse_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("pulse_idx", {24'd0, bus.CHIRP_IDX}, 32'd1);

      // Reset mid-burst
      arm_pulse(16'h0333, 8'd2);
      step(3);
      rset = 1'b1; step(1); rset = 1'b0;
      chk("midrst_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("midrst_lval", {16'd0, bus.CNT_LVAL}, 32'd0);
      chk("midrst_idx", {24'd0, bus.CHIRP_IDX}, 32'd0);
      step(2);
      chk("final_q", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
